// File: rtl/ov7670_reg_init_if.sv
// Write-request bus between the OV7670 register sequencer (master) and the SCCB serialiser (slave).
interface ov7670_reg_init_if;
    logic       write_en;
    logic [7:0] sccb_addr;
    logic [7:0] sccb_data;
    logic       data_finish;

    modport master (
        output write_en,
        output sccb_addr,
        output sccb_data,
        input  data_finish
    );

    modport slave (
        input  write_en,
        input  sccb_addr,
        input  sccb_data,
        output data_finish
    );
endinterface

// File: rtl/ov7670_reg_init.sv
// OV7670 register-initialisation sequencer: walks a fixed table, one SCCB write per entry.
// Define REG_INIT_TIMEOUT_EN to add a 65535-cycle watchdog on the SCCB acknowledge.
module ov7670_reg_init #(
    parameter int POWERUP_WAIT  = 1000,
    parameter int SOFT_RST_WAIT = 5000,
    parameter int GAP_CYCLES    = 16,
    parameter int REG_NUM       = 8
) (
    input  logic                      sclk,
    input  logic                      rst,
    input  logic                      start,
    ov7670_reg_init_if.master         bus,
    output logic [7:0]                reg_index,
    output logic                      busy,
    output logic                      init_done,
    output logic                      timeout_err
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        LOAD,
        WRITE,
        WAIT_ACK,
        RST_WAIT,
        GAP,
        ADVANCE,
        DONE
    } state_t;

    // A wait of 0 cycles behaves as a 1-cycle wait.
    function automatic logic [19:0] last_count(input int cycles);
        return (cycles <= 1) ? 20'd0 : 20'(cycles - 1);
    endfunction

    localparam logic [19:0] PWR_LAST = last_count(POWERUP_WAIT);
    localparam logic [19:0] RST_LAST = last_count(SOFT_RST_WAIT);
    localparam logic [19:0] GAP_LAST = last_count(GAP_CYCLES);
    localparam logic [7:0]  LAST_IDX = 8'(REG_NUM - 1);

`ifdef REG_INIT_TIMEOUT_EN
    localparam logic [19:0] WDOG_LAST = 20'd65534;
`endif

    // NOTE: the table is a constant case function, so it maps to logic with no storage to reset.
    function automatic logic [15:0] table_entry(input logic [7:0] idx);
        case (idx)
            8'd0:    return 16'h1280;
            8'd1:    return 16'h1204;
            8'd2:    return 16'h40D0;
            8'd3:    return 16'h1101;
            8'd4:    return 16'h0C00;
            8'd5:    return 16'h3E00;
            8'd6:    return 16'h8C00;
            8'd7:    return 16'h0400;
            default: return 16'h0000;
        endcase
    endfunction

    state_t      state;
    logic [19:0] cnt;
    logic        ack_seen;

`ifdef REG_INIT_TIMEOUT_EN
    logic timeout_q;
    assign timeout_err = timeout_q;
    assign ack_seen    = bus.data_finish || (cnt == WDOG_LAST);
`else
    assign timeout_err = 1'b0;
    assign ack_seen    = bus.data_finish;
`endif

    // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state         <= PWR_WAIT;
            bus.write_en  <= 1'b0;
            bus.sccb_addr <= 8'h00;
            bus.sccb_data <= 8'h00;
            reg_index     <= 8'd0;
            busy          <= 1'b1;
            init_done     <= 1'b0;
            cnt           <= 20'd0;
`ifdef REG_INIT_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            bus.write_en <= 1'b0;
            case (state)
                PWR_WAIT: begin
                    if (cnt == PWR_LAST) begin
                        state <= LOAD;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                LOAD: begin
                    {bus.sccb_addr, bus.sccb_data} <= table_entry(reg_index);
                    bus.write_en                   <= 1'b1;
                    state                          <= WRITE;
                end
                WRITE: begin
                    cnt   <= 20'd0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_seen) begin
`ifdef REG_INIT_TIMEOUT_EN
                        if (!bus.data_finish) begin
                            timeout_q <= 1'b1;
                        end
`endif
                        cnt   <= 20'd0;
                        state <= (reg_index == 8'd0) ? RST_WAIT : GAP;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == RST_LAST) begin
                        state <= ADVANCE;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ADVANCE;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                ADVANCE: begin
                    if (reg_index == LAST_IDX) begin
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        reg_index <= reg_index + 8'd1;
                        state     <= LOAD;
                    end
                end
                DONE: begin
                    if (start) begin
                        reg_index <= 8'd0;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        state     <= LOAD;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_reg_init.sv
// Directed bench for ov7670_reg_init with a 50-cycle SCCB acknowledge model.
module tb_ov7670_reg_init;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] reg_index;
    logic       busy;
    logic       init_done;
    logic       timeout_err;

    logic model_ack = 1'b0;
    logic spur_ack = 1'b0;
    logic mute_idx2 = 1'b0;

    ov7670_reg_init_if bus ();
    assign bus.data_finish = model_ack | spur_ack;

    ov7670_reg_init #(
        .POWERUP_WAIT (10),
        .SOFT_RST_WAIT(20),
        .GAP_CYCLES   (4),
        .REG_NUM      (8)
    ) dut (
        .sclk       (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus.master),
        .reg_index  (reg_index),
        .busy       (busy),
        .init_done  (init_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] idx;
        logic       busy;
        logic       done;
    } wr_t;

    wr_t  we_log[$];
    int   ack_log[$];
    int   cyc = 0;
    int   cd = 0;
    int   rel_cyc = 0;
    int   done_cyc = -1;
    logic done_prev = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [15:0] exp_pair [8] = '{16'h1280, 16'h1204, 16'h40D0, 16'h1101,
                                  16'h0C00, 16'h3E00, 16'h8C00, 16'h0400};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle log and SCCB model: acknowledge 50 cycles after each write_en, cancelled by reset.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.write_en)
                we_log.push_back('{cyc, bus.sccb_addr, bus.sccb_data, reg_index, busy, init_done});
            if (init_done && !done_prev) done_cyc = cyc;
            done_prev = init_done;
            if (rst) cd = 0;
            model_ack = (cd == 1);
            if (model_ack) ack_log.push_back(cyc);
            if (cd != 0) cd--;
            if (bus.write_en && !rst && !(mute_idx2 && bus.sccb_addr == 8'h40)) cd = 50;
        end
    end

    // what: 0 = write count reaches n, 1 = ack count reaches n, 2 = init_done high.
    task automatic wait_for(input int what, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if ((what == 0 && we_log.size() >= n) ||
                (what == 1 && ack_log.size() >= n) ||
                (what == 2 && init_done === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic reset_and_check(input string ph, input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check({ph, "_write_en"}, bus.write_en, 0);
        check({ph, "_addr_data"}, {bus.sccb_addr, bus.sccb_data}, 16'h0000);
        check({ph, "_reg_index"}, reg_index, 0);
        check({ph, "_busy"}, busy, 1);
        check({ph, "_init_done"}, init_done, 0);
        check({ph, "_timeout_err"}, timeout_err, 0);
        rst = 1'b0;
        #1;
        rel_cyc = cyc;
        we_log.delete();
        ack_log.delete();
        done_cyc = -1;
    endtask

    initial begin
        bit ok;

        // Power-up sequence with start and spurious acks injected while busy.
        reset_and_check("rst", 3);
        repeat (2) @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;

        wait_for(0, 2, 300, ok);
        check("wait_write1", ok, 1);
        spur_ack = 1'b1;
        @(negedge clk);
        #1 spur_ack = 1'b0;

        wait_for(1, 3, 300, ok);
        check("wait_ack2", ok, 1);
        @(negedge clk);
        #1;
        spur_ack = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        #1;
        spur_ack = 1'b0;
        start    = 1'b0;

        wait_for(2, 0, 2000, ok);
        check("wait_done", ok, 1);

        check("first_we_delay", we_log.size() > 0 ? we_log[0].c - rel_cyc + 1 : -1, 12);
        check("write_count", we_log.size(), 8);
        check("ack_count", ack_log.size(), 8);
        for (int i = 0; i < 8 && i < we_log.size(); i++) begin
            check($sformatf("pair%0d", i), {we_log[i].addr, we_log[i].data}, exp_pair[i]);
            check($sformatf("idx%0d", i), we_log[i].idx, i);
            check($sformatf("busy_done%0d", i), {we_log[i].busy, we_log[i].done}, 2'b10);
            if (i > 0 && i <= ack_log.size())
                check($sformatf("gap%0d", i), we_log[i].c - ack_log[i-1], (i == 1) ? 23 : 7);
        end
        if (ack_log.size() == 8)
            check("done_latency", done_cyc - ack_log[7], 6);
        check("done_reg_index", reg_index, 7);
        check("done_busy", busy, 0);
        check("timeout_err_clear", timeout_err, 0);

        // Restart from DONE.
        repeat (5) @(negedge clk);
        #1;
        check("done_hold", {init_done, bus.write_en}, 2'b10);
        we_log.delete();
        ack_log.delete();
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        check("restart_init_done", init_done, 0);
        check("restart_busy", busy, 1);
        check("restart_no_we_yet", bus.write_en, 0);
        @(negedge clk);
        #1;
        check("restart_we", bus.write_en, 1);
        check("restart_pair", {bus.sccb_addr, bus.sccb_data}, 16'h1280);

        // Reset while index 3 is waiting for its acknowledge.
        wait_for(0, 4, 1000, ok);
        check("wait_write3", ok, 1);
        repeat (5) @(negedge clk);
        #1;
        check("midrst_in_flight", reg_index, 3);
        reset_and_check("midrst", 1);
        wait_for(0, 1, 100, ok);
        check("midrst_rewrite", ok, 1);
        check("midrst_we_delay", we_log.size() > 0 ? we_log[0].c - rel_cyc + 1 : -1, 12);
        check("midrst_pair", we_log.size() > 0 ? {we_log[0].addr, we_log[0].data} : 16'hFFFF, 16'h1280);
        wait_for(2, 0, 2000, ok);
        check("midrst_done", ok, 1);
        check("midrst_write_count", we_log.size(), 8);

`ifdef REG_INIT_TIMEOUT_EN
        // Silent SCCB on index 2: watchdog fires, sequence still completes.
        mute_idx2 = 1'b1;
        reset_and_check("to", 1);
        wait_for(2, 0, 70000, ok);
        check("to_done", ok, 1);
        check("to_flag", timeout_err, 1);
        check("to_write_count", we_log.size(), 8);
        check("to_ack_count", ack_log.size(), 7);
        if (we_log.size() >= 4) begin
            check("to_next_pair", {we_log[3].addr, we_log[3].data}, 16'h1101);
            check("to_next_delay", we_log[3].c - we_log[2].c, 65542);
        end
        mute_idx2 = 1'b0;
`else
        check("to_tied_low", timeout_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
